// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding buffer
// so that back-to-back words stream with no idle bit between them.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             s_out,
  output logic             s_frame,
  output logic             s_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             xfer;
  logic             cur_bit;
  logic [WIDTH-1:0] sh_next;

  assign load_ready = !hold_v_q;
  assign xfer       = load_valid && load_ready;
  assign cur_bit    = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
  assign sh_next    = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                                : {1'b0, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          sh_d    = p_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // held word wins; otherwise a fresh word skips the buffer
          if (hold_v_q) begin
            sh_d     = hold_q;
            hold_v_d = 1'b0;
            cnt_d    = '0;
          end else if (xfer) begin
            sh_d  = p_in;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          sh_d  = sh_next;
          cnt_d = cnt_q + 1'b1;
          if (xfer) begin
            hold_d   = p_in;
            hold_v_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s_frame = (state_q == SHIFT);
  assign s_out   = s_frame ? cur_bit : IDLE_LEVEL;
  assign s_last  = s_frame && (cnt_q == LAST);
  assign busy    = s_frame || hold_v_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed vector table, a back-to-back
// stream sequence, and random traffic against a bit-queue model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic [1:0] rst_v = 2'b11;
  logic [1:0] vld_v = 2'b00;
  logic [7:0] p_v [2];
  logic [1:0] so, sf, sl, bz, rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  piso_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
  ) dut0 (
    .clk(clk), .reset(rst_v[0]), .p_in(p_v[0]),
    .load_valid(vld_v[0]), .load_ready(rd[0]),
    .s_out(so[0]), .s_frame(sf[0]), .s_last(sl[0]),
    .busy(bz[0])
  );

  piso_serializer #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
  ) dut1 (
    .clk(clk), .reset(rst_v[1]), .p_in(p_v[1]),
    .load_valid(vld_v[1]), .load_ready(rd[1]),
    .s_out(so[1]), .s_frame(sf[1]), .s_last(sl[1]),
    .busy(bz[1])
  );

  // expected bundle is {s_out, s_frame, s_last, busy, load_ready}
  typedef struct {
    int         dut;
    bit         rst;
    bit         vld;
    logic [7:0] p;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  localparam logic [4:0] IDL = 5'b00001;

  function automatic void add(int d, bit r, bit v,
                              logic [7:0] p, logic [4:0] e);
    vec_t t;
    t.dut = d; t.rst = r; t.vld = v; t.p = p; t.exp = e;
    vecs.push_back(t);
  endfunction

  function automatic logic [4:0] fb(logic b, logic lst, logic rdy);
    return {b, 1'b1, lst, 1'b1, rdy};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic logic [4:0] got(int d);
    return {so[d], sf[d], sl[d], bz[d], rd[d]};
  endfunction

  // random traffic against a queue of {last, bit} entries
  task automatic run_random(int d, bit msb, int ncyc);
    logic [1:0] bq[$];
    logic [4:0] e;
    logic [7:0] w;
    bit r, v, rdy;
    @(negedge clk);
    rst_v[d] = 1'b1; vld_v[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_v[d] = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (bq.size() > 0)
        e = {bq[0][0], 1'b1, bq[0][1], 1'b1, bq.size() <= 8};
      else
        e = IDL;
      chk($sformatf("rand%0d_c%0d", d, c), 32'(got(d)), 32'(e));
      r = ($urandom_range(0, 59) == 0);
      v = ((c / 200) % 2 == 0) ? ($urandom_range(0, 9) != 0)
                               : ($urandom_range(0, 9) < 3);
      w = 8'($urandom);
      rdy = (bq.size() <= 8);
      rst_v[d] = r; vld_v[d] = v; p_v[d] = w;
      @(posedge clk);
      if (r) begin
        bq.delete();
      end else begin
        if (bq.size() > 0) void'(bq.pop_front());
        if (v && rdy)
          for (int i = 0; i < 8; i++)
            bq.push_back({i == 7, msb ? w[7-i] : w[i]});
      end
      @(negedge clk);
    end
    rst_v[d] = 1'b0; vld_v[d] = 1'b0;
  endtask

  initial begin
    logic [7:0] wa, wc, w1, w8;
    logic [7:0] words [3];
    logic [23:0] stream, lmask;
    int nfr, idx, gap;
    bit seen, low, acc;

    p_v[0] = 8'h00; p_v[1] = 8'h00;
    wa = 8'hA5; wc = 8'h3C; w1 = 8'h01; w8 = 8'h80;

    add(0, 1, 1, 8'hFF, IDL);
    add(0, 1, 1, 8'hFF, IDL);
    for (int i = 0; i < 8; i++)
      add(0, 0, i == 0, wa, fb(wa[7-i], i == 7, 1'b1));
    add(0, 0, 0, 8'h00, IDL);
    for (int i = 0; i < 8; i++)
      add(0, 0, i == 0, wa, fb(wa[7-i], i == 7, 1'b1));
    for (int i = 0; i < 8; i++)
      add(0, 0, i == 0, wc, fb(wc[7-i], i == 7, 1'b1));
    add(0, 0, 0, 8'h00, IDL);
    add(0, 0, 1, wa, fb(1'b1, 1'b0, 1'b1));
    add(0, 0, 1, wc, fb(1'b0, 1'b0, 1'b0));
    add(0, 0, 0, 8'h00, fb(1'b1, 1'b0, 1'b0));
    add(0, 1, 0, 8'h00, IDL);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 8'h00, IDL);
    add(0, 1, 1, 8'h77, IDL);
    add(0, 0, 0, 8'h00, IDL);
    add(0, 0, 0, 8'h00, IDL);

    add(1, 1, 0, 8'h00, IDL);
    add(1, 0, 1, w1, fb(w1[0], 1'b0, 1'b1));
    add(1, 0, 1, w8, fb(w1[1], 1'b0, 1'b0));
    for (int i = 2; i < 8; i++)
      add(1, 0, 0, 8'h00, fb(w1[i], i == 7, 1'b0));
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 8'h00, fb(w8[i], i == 7, 1'b1));
    add(1, 0, 0, 8'h00, IDL);

    @(negedge clk);
    rst_v = 2'b11;
    @(posedge clk);
    @(negedge clk);
    rst_v = 2'b00;

    foreach (vecs[k]) begin
      @(negedge clk);
      rst_v = 2'b00; vld_v = 2'b00;
      rst_v[vecs[k].dut] = vecs[k].rst;
      vld_v[vecs[k].dut] = vecs[k].vld;
      p_v[vecs[k].dut] = vecs[k].p;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_dut%0d", k, vecs[k].dut),
          32'(got(vecs[k].dut)), 32'(vecs[k].exp));
    end

    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0;
    @(negedge clk);
    rst_v = 2'b11; vld_v = 2'b00;
    @(posedge clk);
    stream = '0; lmask = '0;
    nfr = 0; idx = 0; gap = 0; seen = 0; low = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rst_v = 2'b00;
      if (sf[0]) begin
        if (seen && nfr == 0) gap++;
        seen = 1;
        nfr++;
        stream = {stream[22:0], so[0]};
        lmask = {lmask[22:0], sl[0]};
      end else if (seen && nfr < 24) begin
        gap++;
      end
      if (!rd[0]) low = 1;
      vld_v[0] = (idx < 3);
      p_v[0] = words[idx < 3 ? idx : 0];
      acc = vld_v[0] && rd[0];
      @(posedge clk);
      if (acc) idx++;
    end
    vld_v[0] = 1'b0;
    chk("b2b_frames", 32'(nfr), 32'd24);
    chk("b2b_stream", 32'(stream), 32'hA53CF0);
    chk("b2b_last", 32'(lmask), 32'h010101);
    chk("b2b_gap", 32'(gap), 32'd0);
    chk("b2b_ready_low", 32'(low), 32'd1);
    chk("b2b_accepted", 32'(idx), 32'd3);

    run_random(0, 1'b1, 2500);
    run_random(1, 1'b0, 2500);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
